seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 150 +++++++++++++++
 tb/tb_seg7_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed seven-segment scanner with a double-buffered display
// Registered active-low outputs, with a ghosting dead band and leading-zero blanking.
module seg7_scan #(
  parameter int NDIG    = 4,
  parameter int CLK_DIV = 50000,
  parameter int DEAD    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp,
  input  logic              load,
  input  logic              lzb,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shad_data_q, disp_data_q;
  logic [NDIG-1:0]   shad_dp_q, disp_dp_q;
  logic              lzb_q;
  logic              run_q;
  logic [7:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              fd_q;

  logic              wrap;
  logic              frame_tick;
  logic              in_dead;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic              zero_run;
  logic              zero_here;

  function automatic logic [6:0] enc7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wrap       = (presc_q == PRESC_MAX);
  assign frame_tick = wrap && (idx_q == IDX_MAX);

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (presc_q < PW'(DEAD));
    end
  endgenerate

  always_comb begin
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Walk from the most significant digit down; zero_run stays set while every
  // digit seen so far is zero, which is exactly the leading-zero blanking set.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    zero_run  = lzb_q;
    zero_here = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_here = zero_run && (disp_data_q[4*i +: 4] == 4'h0) && (i != 0);
      zero_run  = zero_here;
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_data_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = zero_here;
        an_d[i]   = in_dead;
      end
    end
  end

  always_comb begin
    seg_d = 8'hFF;
    if (!in_dead) begin
      seg_d = {~cur_dp, cur_blank ? 7'h7F : enc7(cur_nib)};
    end
  end

  // run_q keeps the first edge after reset release from capturing a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      shad_data_q <= '0;
      shad_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      lzb_q       <= 1'b0;
      run_q       <= 1'b0;
      seg_q       <= 8'hFF;
      an_q        <= '1;
      fd_q        <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      run_q   <= 1'b1;
      if (frame_tick) begin
        disp_data_q <= shad_data_q;
        disp_dp_q   <= shad_dp_q;
        lzb_q       <= lzb;
      end
      if (load && run_q) begin
        shad_data_q <= data;
        shad_dp_q   <= dp;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      fd_q  <= frame_tick;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan against a cycle-count reference model
// Two instances: a 4-digit scanner and a single-digit scanner with no dead band.
module tb_seg7_scan;

  localparam int NA = 4, CA = 8, DA = 2;
  localparam int NB = 1, CB = 4, DB = 0;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data_a = '0;
  logic [3:0]  dp_a = '0;
  logic        load_a = 1'b0;
  logic [3:0]  data_b = '0;
  logic [0:0]  dp_b = '0;
  logic        load_b = 1'b0;
  logic        lzb = 1'b0;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  an_a;
  logic [0:0]  an_b;
  logic        fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  int          na_n, nb_n;
  logic [31:0] disp_a, shad_a, disp_b, shad_b;
  logic [7:0]  dpd_a, shdp_a, dpd_b, shdp_b;
  bit          lzl_a, lzl_b;
  logic [7:0]  es_a, ea_a, es_b, ea_b;
  bit          ef_a, ef_b;
  logic [7:0]  cap [4];

  seg7_scan #(.NDIG(NA), .CLK_DIV(CA), .DEAD(DA)) u_a (
    .clk(clk), .rst_n(rst_n), .data(data_a), .dp(dp_a), .load(load_a), .lzb(lzb),
    .seg(seg_a), .an(an_a), .frame_done(fd_a));

  seg7_scan #(.NDIG(NB), .CLK_DIV(CB), .DEAD(DB)) u_b (
    .clk(clk), .rst_n(rst_n), .data(data_b), .dp(dp_b), .load(load_b), .lzb(lzb),
    .seg(seg_b), .an(an_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs registered from elapsed cycle n: slot and phase follow from n directly.
  function automatic void model_out(input int nd, input int cd, input int dd, input int n,
                                    input logic [31:0] disp, input logic [7:0] dpv, input bit lz,
                                    output logic [7:0] s, output logic [7:0] a);
    int ph, sl;
    logic [7:0] e;
    logic [3:0] nib;
    bit blank;
    ph = n % cd;
    sl = (n / cd) % nd;
    a = 8'hFF;
    s = 8'hFF;
    if (ph >= dd) begin
      a[sl] = 1'b0;
      nib = 4'((disp >> (4 * sl)) & 32'hF);
      blank = lz && (sl > 0) && ((disp >> (4 * sl)) == 32'h0);
      e = SEG_TBL[nib];
      s = {~dpv[sl], blank ? 7'h7F : e[6:0]};
    end
  endfunction

  task automatic model_reset();
    na_n = 0; nb_n = 0;
    disp_a = '0; shad_a = '0; disp_b = '0; shad_b = '0;
    dpd_a = '0; shdp_a = '0; dpd_b = '0; shdp_b = '0;
    lzl_a = 1'b0; lzl_b = 1'b0;
  endtask

  task automatic cyc();
    model_out(NA, CA, DA, na_n, disp_a, dpd_a, lzl_a, es_a, ea_a);
    ef_a = ((na_n + 1) % (NA * CA)) == 0;
    if (ef_a) begin disp_a = shad_a; dpd_a = shdp_a; lzl_a = lzb; end
    if (load_a) begin shad_a = {16'h0, data_a}; shdp_a = {4'h0, dp_a}; end
    na_n++;
    model_out(NB, CB, DB, nb_n, disp_b, dpd_b, lzl_b, es_b, ea_b);
    ef_b = ((nb_n + 1) % (NB * CB)) == 0;
    if (ef_b) begin disp_b = shad_b; dpd_b = shdp_b; lzl_b = lzb; end
    if (load_b) begin shad_b = {28'h0, data_b}; shdp_b = {7'h0, dp_b}; end
    nb_n++;
    @(posedge clk);
    @(negedge clk);
    check8("seg_a", seg_a, es_a);
    check8("an_a", {4'hF, an_a}, ea_a);
    check8("frame_done_a", {7'h0, fd_a}, {7'h0, ef_a});
    check8("seg_b", seg_b, es_b);
    check8("an_b", {7'h7F, an_b}, ea_b);
    check8("frame_done_b", {7'h0, fd_b}, {7'h0, ef_b});
    if (an_a != 4'hF) begin
      for (int i = 0; i < 4; i++) if (!an_a[i]) cap[i] = seg_a;
    end
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic cap_clear();
    for (int i = 0; i < 4; i++) cap[i] = 8'h00;
  endtask

  task automatic cap_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    check8({tag, "_d0"}, cap[0], e0);
    check8({tag, "_d1"}, cap[1], e1);
    check8({tag, "_d2"}, cap[2], e2);
    check8({tag, "_d3"}, cap[3], e3);
  endtask

  task automatic load_a_now(input logic [15:0] d, input logic [3:0] p);
    data_a = d; dp_a = p; load_a = 1'b1;
    cyc();
    load_a = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check8({tag, "_seg_a"}, seg_a, 8'hFF);
    check8({tag, "_an_a"}, {4'h0, an_a}, 8'h0F);
    check8({tag, "_fd_a"}, {7'h0, fd_a}, 8'h00);
    check8({tag, "_seg_b"}, seg_b, 8'hFF);
    check8({tag, "_an_b"}, {7'h0, an_b}, 8'h01);
    check8({tag, "_fd_b"}, {7'h0, fd_b}, 8'h00);
  endtask

  initial begin
    int t;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    cap_clear(); run(32);
    cap_check("boot", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Load on the frame_done cycle: held for one full frame, then shown.
    cap_clear();
    data_b = 4'h7; load_b = 1'b1;
    load_a_now(16'h12AF, 4'h0);
    load_b = 1'b0;
    run(31);
    cap_check("coincident_load", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    cap_clear(); run(32);
    cap_check("hex_12af", 8'h8E, 8'h88, 8'hA4, 8'hF9);
    check8("single_seg", seg_b, 8'hF8);
    check8("single_an", {7'h0, an_b}, 8'h00);

    cap_clear(); run(10);
    load_a_now(16'h1234, 4'h0);
    run(21);
    cap_check("midframe_hold", 8'h8E, 8'h88, 8'hA4, 8'hF9);
    cap_clear(); run(32);
    cap_check("hex_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    lzb = 1'b1;
    load_a_now(16'h0050, 4'b1000);
    run(31);
    cap_clear(); run(32);
    cap_check("lzb_0050", 8'hC0, 8'h92, 8'hFF, 8'h7F);

    load_a_now(16'h0000, 4'h0);
    run(31);
    cap_clear(); run(32);
    cap_check("lzb_zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    for (int k = 0; k < 1500; k++) begin
      load_a = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < 4; j++) data_a[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      dp_a = 4'($urandom);
      load_b = ($urandom_range(0, 5) == 0);
      data_b = 4'($urandom);
      dp_b = 1'($urandom);
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      cyc();
    end
    load_a = 1'b0; load_b = 1'b0;

    t = 0;
    while (!fd_a && t < 100) begin cyc(); t++; end
    check8("sync_frame_done", {7'h0, fd_a}, 8'h01);
    run(19);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cap_clear();
    cyc(); check8("post_reset_dead0", {4'h0, an_a}, 8'h0F);
    cyc(); check8("post_reset_dead1", {4'h0, an_a}, 8'h0F);
    cyc(); check8("post_reset_slot0_an", {4'h0, an_a}, 8'h0E);
    check8("post_reset_slot0_seg", seg_a, 8'hC0);
    run(29);
    cap_check("post_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
